// File: rtl/jump_label_loader.sv
// Boot-time loader for the jump-label table: scans instruction memory for label
// markers and records each marker's address, with a combinational read port.
module jump_label_loader #(
  parameter int                     ADDR_W  = 16,
  parameter int                     INSTR_W = 9,
  parameter logic [INSTR_W-5:0]     MARK_OP = 5'b11111,
  parameter int                     LABELS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic              busy,
  output logic              done,
  output logic              dup_err,
  output logic [4:0]        label_count,
  input  logic [3:0]        lut_idx,
  output logic [ADDR_W-1:0] lut_target,
  output logic              lut_valid
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   len;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   pipe_addr;
  logic                pipe_vld;
  logic [LABELS-1:0]   valid;
  logic [ADDR_W-1:0]   target [LABELS];

  logic                last_issue;
  logic                is_marker;
  logic [3:0]          mark_idx;
  logic                accept;

  assign accept     = (state == IDLE) && start;
  assign last_issue = (state == SCAN) && (cnt == len - ADDR_W'(1));
  assign is_marker  = (imem_data[INSTR_W-1:4] == MARK_OP);
  assign mark_idx   = imem_data[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (prog_len == '0) ? FINISH : SCAN;
      SCAN:    if (last_issue) state_nxt = DRAIN;
      DRAIN:   state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == SCAN) || (state == DRAIN);
  assign done      = (state == FINISH);
  assign imem_rd   = (state == SCAN);
  assign imem_addr = cnt;

  // NOTE: the table storage is reset too, because a reset must leave no trace of a prior scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len         <= '0;
      cnt         <= '0;
      pipe_addr   <= '0;
      pipe_vld    <= 1'b0;
      valid       <= '0;
      dup_err     <= 1'b0;
      label_count <= '0;
      for (int i = 0; i < LABELS; i++) target[i] <= '0;
    end else begin
      pipe_vld  <= (state == SCAN);
      pipe_addr <= cnt;

      if (accept) begin
        len         <= prog_len;
        cnt         <= '0;
        valid       <= '0;
        dup_err     <= 1'b0;
        label_count <= '0;
      end else if ((state == SCAN) && !last_issue) begin
        cnt <= cnt + ADDR_W'(1);
      end

      // Data for the read issued last cycle is on imem_data now; first occurrence wins.
      if (pipe_vld && is_marker) begin
        if (!valid[mark_idx]) begin
          valid[mark_idx]  <= 1'b1;
          target[mark_idx] <= pipe_addr;
          label_count      <= label_count + 5'd1;
        end else begin
          dup_err <= 1'b1;
        end
      end
    end
  end

  assign lut_valid  = valid[lut_idx];
  assign lut_target = valid[lut_idx] ? target[lut_idx] : '0;

endmodule

// File: tb/tb_jump_label_loader.sv
// Randomized and directed bench for jump_label_loader, checked every cycle
// against a prefix-scan model of the label table and the scan timeline.
module tb_jump_label_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] prog_len;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [8:0]  imem_data;
  logic        busy, done, dup_err;
  logic [4:0]  label_count;
  logic [3:0]  lut_idx;
  logic [15:0] lut_target;
  logic        lut_valid;

  jump_label_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .busy(busy), .done(done), .dup_err(dup_err), .label_count(label_count),
    .lut_idx(lut_idx), .lut_target(lut_target), .lut_valid(lut_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int cur_len = 0;
  bit mon_on = 1'b0;

  logic [8:0]  mem [256];
  bit          m_valid [16];
  logic [15:0] m_tgt [16];
  int          m_cnt;
  bit          m_dup;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory answers one cycle after a read; garbage otherwise so stale data is never trusted.
  always @(posedge clk) imem_data <= imem_rd ? mem[imem_addr[7:0]] : 9'($urandom);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] mk(input int idx);
    return {5'h1f, 4'(idx)};
  endfunction

  function automatic logic [8:0] non_marker();
    return {5'($urandom_range(0, 30)), 4'($urandom)};
  endfunction

  // Table as it must look once the first p program words have been processed.
  function automatic void build_model(input int p);
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tgt[i]   = '0;
    end
    m_cnt = 0;
    m_dup = 1'b0;
    for (int a = 0; a < p; a++) begin
      if (mem[a][8:4] == 5'h1f) begin
        if (m_valid[mem[a][3:0]]) m_dup = 1'b1;
        else begin
          m_valid[mem[a][3:0]] = 1'b1;
          m_tgt[mem[a][3:0]]   = 16'(a);
          m_cnt++;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    int t, p;
    bit eb, er, ed;
    if (rst_n && mon_on) begin
      t = cyc - start_cyc + 1;
      if (cur_len == 0) begin
        eb = 1'b0; er = 1'b0; ed = (t == 1); p = 0;
      end else begin
        eb = (t <= cur_len + 1);
        er = (t <= cur_len);
        ed = (t == cur_len + 2);
        p  = t - 2;
        if (p < 0) p = 0;
        if (p > cur_len) p = cur_len;
      end
      check("busy", busy, eb);
      check("imem_rd", imem_rd, er);
      check("done", done, ed);
      if (er) check("imem_addr", imem_addr, 32'(t - 1));
      build_model(p);
      check("label_count", label_count, 32'(m_cnt));
      check("dup_err", dup_err, m_dup);
      check("lut_valid", lut_valid, m_valid[lut_idx]);
      check("lut_target", lut_target, m_tgt[lut_idx]);
      lut_idx = 4'($urandom);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = non_marker();
  endtask

  task automatic launch(input int len);
    mon_on = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    prog_len = 16'(len);
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    cur_len   = len;
    mon_on    = 1'b1;
  endtask

  task automatic run_scan(input int len, output int lat);
    launch(len);
    lat = -1;
    for (int i = 0; i < len + 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - start_cyc + 1;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
    else check("latency", lat, (len == 0) ? 1 : len + 2);
    @(negedge clk);
    mon_on = 1'b0;
  endtask

  task automatic peek(input int idx, input logic v, input logic [15:0] tg);
    lut_idx = 4'(idx);
    #1;
    check($sformatf("lut_valid[%0d]", idx), lut_valid, v);
    check($sformatf("lut_target[%0d]", idx), lut_target, tg);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; prog_len = '0; lut_idx = '0;
    clear_mem();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd", imem_rd, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_count", label_count, 0);
    check("rst_dup", dup_err, 0);
    peek(5, 1'b0, 16'h0);

    // Two markers in an 8-word program.
    clear_mem();
    mem[2] = mk(3);
    mem[5] = mk(7);
    run_scan(8, lat);
    check("t1_latency", lat, 10);
    check("t1_count", label_count, 2);
    peek(3, 1'b1, 16'd2);
    peek(7, 1'b1, 16'd5);
    peek(0, 1'b0, 16'd0);

    // Rescan without markers wipes the table.
    clear_mem();
    run_scan(4, lat);
    check("rescan_dup", dup_err, 0);
    check("rescan_count", label_count, 0);
    for (int i = 0; i < 16; i++) peek(i, 1'b0, 16'd0);

    // Duplicate label keeps its first address.
    clear_mem();
    mem[1] = mk(6);
    mem[4] = mk(6);
    run_scan(6, lat);
    peek(6, 1'b1, 16'd1);
    check("dup_flag", dup_err, 1);
    check("dup_count", label_count, 1);

    // Empty program.
    run_scan(0, lat);
    check("empty_latency", lat, 1);
    check("empty_count", label_count, 0);

    // Reset in the middle of a scan.
    clear_mem();
    mem[0] = mk(2);
    mem[1] = mk(2);
    mem[2] = mk(4);
    launch(10);
    repeat (3) @(negedge clk);
    check("pre_reset_count", label_count, 1);
    mon_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd", imem_rd, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_count", label_count, 0);
    check("mid_rst_dup", dup_err, 0);
    for (int i = 0; i < 16; i++) peek(i, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Start pulsed while busy is ignored.
    clear_mem();
    mem[7] = mk(1);
    fork
      run_scan(12, lat);
      begin
        repeat (5) @(negedge clk);
        start = 1'b1;
        prog_len = 16'd3;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("busy_start_latency", lat, 14);
    peek(1, 1'b1, 16'd7);

    // Markers at the first and last address.
    clear_mem();
    mem[0]  = mk(1);
    mem[15] = mk(9);
    run_scan(16, lat);
    peek(1, 1'b1, 16'd0);
    peek(9, 1'b1, 16'd15);
    check("edge_count", label_count, 2);

    // Every index marked, plus one duplicate.
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i + 2] = mk(15 - i);
    mem[19] = mk(4);
    run_scan(20, lat);
    check("full_count", label_count, 16);
    check("full_dup", dup_err, 1);
    peek(15, 1'b1, 16'd2);
    peek(0, 1'b1, 16'd17);

    // Random programs.
    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(1, 60);
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 2) == 0) ? mk($urandom_range(0, 15)) : non_marker();
      run_scan(len, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jump_label_loader.md
Name: jump_label_loader

Overview:
- Boot-time writer for the jump-label table that the branch-target select logic reads.
- On start, it streams instruction memory from address 0 to prog_len-1 and detects label-marker instructions.
- For each marker, it records the marker's instruction address into a 16-entry label table indexed by the marker's label field.
- The table has a combinational read port (lut_idx -> lut_target) that feeds the branch-target mux in place of a hard-coded label list.

Parameters:
- ADDR_W, 16, width of instruction addresses and stored targets
- INSTR_W, 9, instruction word width
- MARK_OP, 5'b11111, opcode value in instr[INSTR_W-1:4] identifying a label marker
- LABELS, 16, table depth; fixed at 16 (4-bit index)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a scan (ignored while busy)
- prog_len  in  ADDR_W  number of instructions to scan; sampled on accepted start
- imem_addr  out  ADDR_W  instruction memory read address
- imem_rd  out  1  read strobe; data valid on imem_data exactly 1 cycle later
- imem_data  in  INSTR_W  instruction memory read data
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the scan completes
- dup_err  out  1  sticky; a label index was seen twice in one scan
- label_count  out  5  number of distinct labels recorded (0..16)
- lut_idx  in  4  table read index
- lut_target  out  ADDR_W  stored target for lut_idx; 0 if the entry is invalid
- lut_valid  out  1  entry lut_idx has been written in the current scan

Behaviour:
- Reset (async, rst_n=0) puts the block in the following state:
  - FSM in IDLE.
  - imem_addr=0, imem_rd=0, busy=0, done=0, dup_err=0, label_count=0.
  - All valid bits cleared and all targets=0.
  - This applies mid-scan too: the scan is abandoned and no partial table survives.
- FSM states are IDLE, SCAN, DRAIN, FINISH.
- IDLE:
  - start=1 latches prog_len, clears all valid bits, clears dup_err and label_count, and resets the address counter to 0.
  - If prog_len=0, go to FINISH. Otherwise go to SCAN.
- SCAN:
  - Each cycle drive imem_rd=1 and imem_addr=counter, increment the counter, and remember the issued address in a 1-stage pipe register.
  - When the counter issues prog_len-1, go to DRAIN on the next cycle.
- Marker processing (SCAN and DRAIN):
  - A marker is checked on the cycle after each issued read, using imem_data with the pipe address.
  - Marker condition: imem_data[INSTR_W-1:4]==MARK_OP. The index is imem_data[3:0].
  - If the entry is not valid: write target=pipe address, set valid, label_count+1.
  - If the entry is already valid: keep the first occurrence unchanged and set dup_err=1.
- DRAIN: imem_rd=0; process the final returned word, then go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in that same cycle, return to IDLE.
- busy is high in SCAN and DRAIN only.
- Total latency from start to done:
  - prog_len+2 cycles when prog_len>0;
  - 1 cycle when prog_len=0.
- start while busy or in FINISH is ignored; no restart and no state change.
- Read port:
  - Purely combinational from the table registers.
  - Table writes are registered, so a same-cycle read of an index being written returns the old value.
  - Reads during a scan show the partially built table.
- label_count saturates naturally at 16 because indices are 4 bits.
- Targets are stored as full ADDR_W addresses and are not truncated.
- The address counter stops at prog_len-1 and never wraps, even for prog_len=2^ADDR_W-1.

Test Plan:
- Scan with markers:
  - Stimulus: reset, then start with prog_len=8; memory holds markers for idx 3 at addr 2 and idx 7 at addr 5, with the rest non-markers.
  - Response: done 10 cycles after start; label_count=2; lut_idx=3 -> 2 (valid); lut_idx=7 -> 5 (valid); lut_idx=0 -> valid=0, target=0.
- Duplicate label:
  - Stimulus: markers for idx 6 at addr 1 and addr 4, prog_len=6.
  - Response: lut_idx=6 -> 1; dup_err=1; label_count=1.
- Empty program: start with prog_len=0 -> done on the next cycle, imem_rd never asserted, label_count=0.
- Rescan clears the table: after the first test, start with prog_len=4 and no markers -> all lut_valid=0, dup_err=0.
- Edge cases around a scan:
  - Reset mid-scan: rst_n low at cycle 3 of a 10-word scan -> all outputs immediately at reset values, all entries invalid.
  - start pulsed again while busy -> ignored, and done is still at the original cycle.
- Boundary addresses:
  - Markers at addr 0 and at addr prog_len-1 (e.g. 15 with prog_len=16) -> both recorded correctly.
  - All 16 indices marked -> label_count=16.
